// File: rtl/ram_valid_pkg.sv
// Shared types and elaboration-time helpers for the validated dual-port RAM.
package ram_valid_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } ram_valid_state_t;

  // Widest valid vector popcount accepts; callers size-cast into it.
  localparam int unsigned POP_MAX_W = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ram_valid_dp.sv
// Simple-dual-port RAM with per-entry valid bits, invalidate port, live valid
// count and a background scrub engine that clears the whole array.
module ram_valid_dp
  import ram_valid_pkg::*;
#(
  parameter int                      ADDR_W     = 4,
  parameter int                      DATA_W     = 4,
  parameter logic [(2**ADDR_W)-1:0]  RST_VALID  = '0,
  parameter logic [DATA_W-1:0]       FILL_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              inv_en_i,
  input  logic [ADDR_W-1:0] inv_addr_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_hit_o,
  input  logic              clr_i,
  output logic              busy_o,
  output logic [ADDR_W:0]   valid_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   RST_CNT  = (ADDR_W+1)'(popcount(POP_MAX_W'(RST_VALID)));
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  ram_valid_state_t  state_q, state_d;
  logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_hit_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic busy, last, inc, dec;

  assign busy = (state_q == SCRUB);
  assign last = busy && (scrub_cnt_q == LAST_IDX);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      scrub_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
    end
  end

  // FSM: next state; the scrub counter wraps to 0 on the exit cycle
  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d     = SCRUB;
          scrub_cnt_d = '0;
        end
      end
      SCRUB: begin
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == SCRUB);
  end

  // Valid vector and count; a same-address write overrides the invalidate.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    dec     = 1'b0;
    if (busy) begin
      valid_d[scrub_cnt_q] = 1'b0;
      if (last)                      cnt_d = '0;
      else if (valid_q[scrub_cnt_q]) cnt_d = cnt_q - CNT_ONE;
    end else begin
      if (inv_en_i && !(wr_en_i && (wr_addr_i == inv_addr_i))) begin
        valid_d[inv_addr_i] = 1'b0;
        dec                 = valid_q[inv_addr_i];
      end
      if (wr_en_i) begin
        valid_d[wr_addr_i] = 1'b1;
        inc                = !valid_q[wr_addr_i];
      end
      cnt_d = cnt_q + (inc ? CNT_ONE : '0) - (dec ? CNT_ONE : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= RST_VALID;
      cnt_q   <= RST_CNT;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is not reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (busy)         mem_q[scrub_cnt_q] <= FILL_VALUE;
    else if (wr_en_i) mem_q[wr_addr_i]   <= wr_data_i;
  end

  // Read-first: old data and old valid bit are sampled at the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else if (rd_en_i) begin
      rd_valid_q <= 1'b1;
      rd_hit_q   <= valid_q[rd_addr_i];
      rd_data_q  <= valid_q[rd_addr_i] ? mem_q[rd_addr_i] : '0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_hit_o    = rd_hit_q;
  assign valid_cnt_o = cnt_q;

endmodule

// File: tb/tb_ram_valid_dp.sv
// Directed bench for ram_valid_dp: vector table for single-cycle behaviour,
// hand-written sequences for scrub and reset-during-scrub.
module tb_ram_valid_dp;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int W      = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, inv_en, rd_en, clr;
  logic [ADDR_W-1:0] wr_addr, inv_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_hit, busy;
  logic [ADDR_W:0]   valid_cnt;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  ram_valid_dp #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RST_VALID (16'h3F1D),
    .FILL_VALUE(4'h0)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .inv_en_i   (inv_en),
    .inv_addr_i (inv_addr),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .rd_hit_o   (rd_hit),
    .clr_i      (clr),
    .busy_o     (busy),
    .valid_cnt_o(valid_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              inv_en;
    logic [ADDR_W-1:0] inv_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   exp_cnt;
    logic              exp_hit;
    logic [DATA_W-1:0] exp_data;
    logic              chk_data;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic we, input int wa, input int wd,
                              input logic ie, input int ia,
                              input logic re, input int ra,
                              input int cnt, input logic hit, input int d, input logic cd);
    vec_t v;
    v.wr_en = we;  v.wr_addr = ADDR_W'(wa); v.wr_data = DATA_W'(wd);
    v.inv_en = ie; v.inv_addr = ADDR_W'(ia);
    v.rd_en = re;  v.rd_addr = ADDR_W'(ra);
    v.exp_cnt = (ADDR_W+1)'(cnt); v.exp_hit = hit; v.exp_data = DATA_W'(d); v.chk_data = cd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    inv_en = 0; inv_addr = '0;
    rd_en = 0; rd_addr = '0; clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a, input logic exp_hit, input int exp_d, input string name);
    logic [W-1:0] e;
    idle_inputs();
    rd_en = 1; rd_addr = ADDR_W'(a);
    exp_q.push_back({exp_hit, DATA_W'(exp_d)});
    step();
    rd_en = 0;
    e = exp_q.pop_front();
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check({name, "_hit"},   32'(rd_hit),   32'(e[W-1]));
    check({name, "_data"},  32'(rd_data),  32'(e[DATA_W-1:0]));
  endtask

  initial begin
    int n;
    logic [W-1:0] e;
    idle_inputs();
    rst_n = 0;

    // Initial valid set {0,2,3,4,8..13}; count 10.
    vecs[0]  = mk(0, 0, 0,   0, 0, 1, 1,  10, 0, 0,   1);
    vecs[1]  = mk(0, 0, 0,   0, 0, 1, 0,  10, 1, 0,   0);
    vecs[2]  = mk(1, 1, 'hA, 0, 0, 0, 0,  11, 0, 0,   0);
    vecs[3]  = mk(0, 0, 0,   0, 0, 1, 1,  11, 1, 'hA, 1);
    vecs[4]  = mk(1, 7, 3,   0, 0, 0, 0,  12, 0, 0,   0);
    vecs[5]  = mk(1, 7, 5,   1, 7, 1, 7,  12, 1, 3,   1);
    vecs[6]  = mk(0, 0, 0,   0, 0, 1, 7,  12, 1, 5,   1);
    vecs[7]  = mk(0, 0, 0,   1, 1, 0, 0,  11, 0, 0,   0);
    vecs[8]  = mk(0, 0, 0,   1, 1, 1, 1,  11, 0, 0,   1);
    vecs[9]  = mk(0, 0, 0,   0, 0, 1, 1,  11, 0, 0,   1);
    vecs[10] = mk(1, 5, 9,   1, 3, 0, 0,  11, 0, 0,   0);
    vecs[11] = mk(1, 12, 'hC, 1, 5, 1, 3, 10, 0, 0,   1);
    vecs[12] = mk(1, 14, 'hE, 0, 0, 1, 12, 11, 1, 'hC, 1);
    vecs[13] = mk(0, 0, 0,   0, 0, 1, 14, 11, 1, 'hE, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt",      32'(valid_cnt), 32'd10);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_rd_valid", 32'(rd_valid),  32'd0);
    check("rst_rd_hit",   32'(rd_hit),    32'd0);
    check("rst_rd_data",  32'(rd_data),   32'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    check("post_rst_cnt", 32'(valid_cnt), 32'd10);

    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].wr_en;   wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      inv_en = vecs[i].inv_en; inv_addr = vecs[i].inv_addr;
      rd_en = vecs[i].rd_en;   rd_addr = vecs[i].rd_addr;
      if (vecs[i].rd_en) exp_q.push_back({vecs[i].exp_hit, vecs[i].exp_data});
      step();
      check($sformatf("v%0d_cnt", i), 32'(valid_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rd_en));
      if (vecs[i].rd_en) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_hit", i), 32'(rd_hit), 32'(e[W-1]));
        if (vecs[i].chk_data) check($sformatf("v%0d_data", i), 32'(rd_data), 32'(e[DATA_W-1:0]));
      end
    end

    // Scrub launched together with a write: write lands (count 12), then cleared.
    idle_inputs();
    clr = 1; wr_en = 1; wr_addr = 4'hF; wr_data = 4'hF;
    step();
    idle_inputs();
    check("clr_busy_rise", 32'(busy),      32'd1);
    check("clr_wr_cnt",    32'(valid_cnt), 32'd12);
    n = 0;
    while (busy && n < 40) begin
      idle_inputs();
      if (n == 3) begin
        wr_en = 1; wr_addr = 4'h0; wr_data = 4'h7;
        inv_en = 1; inv_addr = 4'h0;
      end
      if (n == 5) clr = 1;
      step();
      n++;
    end
    idle_inputs();
    check("scrub_busy_len", 32'(n),         32'd16);
    check("scrub_cnt_zero", 32'(valid_cnt), 32'd0);
    step();
    check("scrub_no_restart", 32'(busy), 32'd0);
    for (int a = 0; a < 16; a++) do_read(a, 1'b0, 0, $sformatf("scrub_rd%0d", a));
    check("scrub_cnt_after_rd", 32'(valid_cnt), 32'd0);

    // Reset during scrub: addresses 12.. keep data, valid reloads.
    idle_inputs();
    wr_en = 1; wr_addr = 4'd12; wr_data = 4'hB;
    step();
    check("pre_scrub2_cnt", 32'(valid_cnt), 32'd1);
    idle_inputs();
    clr = 1;
    step();
    idle_inputs();
    check("scrub2_busy", 32'(busy), 32'd1);
    repeat (8) step();
    check("scrub2_busy_c8", 32'(busy), 32'd1);
    #2 rst_n = 0;
    #1;
    check("midrst_busy",     32'(busy),      32'd0);
    check("midrst_cnt",      32'(valid_cnt), 32'd10);
    check("midrst_rd_valid", 32'(rd_valid),  32'd0);
    @(negedge clk);
    rst_n = 1;
    do_read(12, 1'b1, 'hB, "midrst_rd12");
    do_read(5,  1'b0, 0,   "midrst_rd5");
    do_read(0,  1'b1, 0,   "midrst_rd0");
    check("midrst_busy_after", 32'(busy), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
